sdram_dev_model: RTL and testbench
==================================

Name: sdram_dev_model

Overview:
Parametrised, cycle-accurate SDR SDRAM device model. It is the successor to the fixed 16-bit, DPI-backed sdram model. Storage is internal; it adds a programmable mode register (burst length, CAS latency, write-burst mode), full write bursts with DQM byte masking, per-bank open rows, precharge and auto-precharge, refresh, burst interruption and protocol-error reporting. It sits on the SoC's SDRAM pins as the device behind the SDRAM controller and is used in simulation and FPGA-emulation builds.

Parameters:
DQ_W, 16, data width in bits; 8, 16 or 32. Byte lanes NB = DQ_W/8.
ROW_W, 13, row address bits.
COL_W, 9, column address bits; must be 10 or less.
BANK_W, 2, bank address bits.
A_W, 13, address pin width; must be at least max(ROW_W, 11).

Ports:
clk  in  1  device clock; all sampling on the rising edge.
reset  in  1  synchronous, active-high.
cke  in  1  clock enable; 0 freezes the model.
cs  in  1  chip select, active-low.
ras  in  1  row strobe, active-low.
cas  in  1  column strobe, active-low.
we  in  1  write enable, active-low.
a  in  A_W  row, column and mode address; bit 10 is the auto-precharge / all-banks flag.
ba  in  BANK_W  bank select.
dqm  in  NB  byte mask, 1 = masked.
dq  inout  DQ_W  data bus; driven by the model only during read data.
refresh_cnt  out  16  count of accepted REFRESH commands; wraps.
proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (sampled while reset=1, regardless of cke):
  - Mode register = BL 1, CL 2, burst writes enabled.
  - All banks closed; burst engine idle; read pipeline empty.
  - dq high-Z; refresh_cnt = 0; proto_err = 0.
  - Memory contents are preserved.
- Freeze: when cke=0 and reset=0, no command is sampled and every register holds, including the pipeline and dq drive.
- Command decode: cmd = {cs,ras,cas,we}. cs=1 is treated as NOP. Command codes:
  - 0111 NOP
  - 0011 ACTIVE
  - 0101 READ
  - 0100 WRITE
  - 0110 BURST_TERMINATE
  - 0010 PRECHARGE
  - 0001 REFRESH
  - 0000 LOAD_MODE
- LOAD_MODE:
  - a[2:0] selects burst length: 000 = 1, 001 = 2, 010 = 4, 011 = 8.
  - a[6:4] selects CAS latency: 010 = CL2, 011 = CL3.
  - a[9]=1 selects single-location writes.
  - Any other encoding sets proto_err and leaves the mode register unchanged.
  - LOAD_MODE with any bank open sets proto_err and is ignored.
- ACTIVE: open[ba] = 1; row[ba] = a[ROW_W-1:0]. ACTIVE to an already-open bank sets proto_err and still updates the row.
- READ/WRITE:
  - Target bank must be open; otherwise proto_err is set and the command is ignored.
  - Start column c = a[COL_W-1:0].
  - Burst word k uses column {c[COL_W-1:log2 BL], (c[log2 BL-1:0]+k) mod BL}, i.e. sequential and wrapping inside the BL-aligned block.
  - Memory index = {row[ba], ba, column}.
  - a[10] requests auto-precharge: the bank closes on the edge after the last burst word.
- READ timing:
  - For a READ sampled at edge n, word k is fetched at edge n+k and pushed into a CL-deep pipeline.
  - Word k is driven from just after edge n+CL-1+k so the controller samples it at edge n+CL+k.
  - DQM read latency is 2: dqm sampled at edge m tri-states the masked byte lanes of the word sampled at edge m+2.
  - dq returns to high-Z once the pipeline is empty.
- WRITE timing:
  - For a WRITE sampled at edge n, word k is taken from dq at edge n+k, with dqm at that same edge masking byte lanes.
  - Burst length is BL, or 1 in single-write mode.
  - dq is never driven by the model during a write.
- Interruption:
  - A new READ or WRITE restarts the burst engine; the old burst stops issuing words at that edge.
  - Read words already in the pipeline are still delivered unless a WRITE arrives.
  - A WRITE flushes the pipeline and releases dq at that edge.
  - BURST_TERMINATE stops word issue at that edge; pending pipeline words still drain.
  - PRECHARGE to the bursting bank acts as BURST_TERMINATE plus bank close.
- PRECHARGE: a[10]=1 closes all banks; otherwise only ba. Precharging a closed bank is legal and does nothing.
- REFRESH: all banks must be closed; otherwise proto_err is set and refresh_cnt does not increment. If legal, refresh_cnt increments by 1, wrapping 0xFFFF to 0.
- Timing parameters (tRCD, tRP, tRFC) are not checked.

Test Plan:
- Reset → LOAD_MODE a=0x022 (BL4, CL2) → ACTIVE ba=1 row 0x0AB → WRITE col 0x004 with dq 0x1111, 0x2222, 0x3333, 0x4444 on edges n..n+3 → READ col 0x004 at edge r → controller samples 0x1111..0x4444 at edges r+2..r+5; dq high-Z at r+6.
- CL3, BL4, READ col 0x006 → words sampled in wrap order for columns 6, 7, 4, 5 at edges r+3..r+6.
- WRITE BL4 to a location holding 0xFFFF with dqm=01 on word 1 → word 1 reads back 0x22FF (upper byte written, lower byte 0xFF preserved); the other three words are unchanged.
- READ BL8 then BURST_TERMINATE at r+2 (CL2) → exactly 3 words sampled (r+2..r+4), then high-Z.
- READ with a[10]=1 → bank closed after the burst; a following READ without ACTIVE → proto_err=1 and dq stays high-Z.
- REFRESH with bank 0 open → proto_err=1 and refresh_cnt stays 0; after PRECHARGE a[10]=1 and two REFRESH commands → refresh_cnt=2. Holding cke=0 for 5 cycles mid-read → data resumes at the same word after cke returns to 1.

Source files
------------

// File: rtl/sdram_dev_model.sv
// sdram_dev_model: cycle-accurate SDR SDRAM device with internal storage,
// mode register, bursts, DQM masking, per-bank rows, refresh, error flag.
module sdram_dev_model #(
  parameter int DQ_W   = 16,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int A_W    = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cke,
  input  logic              cs,
  input  logic              ras,
  input  logic              cas,
  input  logic              we,
  input  logic [A_W-1:0]    a,
  input  logic [BANK_W-1:0] ba,
  input  logic [DQ_W/8-1:0] dqm,
  inout  wire  [DQ_W-1:0]   dq,
  output logic [15:0]       refresh_cnt,
  output logic              proto_err
);
  localparam int NB  = DQ_W / 8;
  localparam int NBK = 1 << BANK_W;
  localparam int MW  = ROW_W + BANK_W + COL_W;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_BST = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} bst_e;

  logic [DQ_W-1:0] mem [1<<MW];

  logic [1:0]        bl_q;
  logic              cl3_q;
  logic              swr_q;
  logic [NBK-1:0]    open_q;
  logic [NBK-1:0]    open_d;
  logic [ROW_W-1:0]  row_q [NBK];
  bst_e              bst_q;
  logic [BANK_W-1:0] bbank_q;
  logic [ROW_W-1:0]  brow_q;
  logic [COL_W-1:0]  bcol_q;
  logic [1:0]        bblc_q;
  logic [2:0]        bk_q;
  logic [2:0]        blast_q;
  logic              bap_q;
  logic              pcl_q;
  logic [BANK_W-1:0] pbank_q;
  logic [2:0]        pv_q;
  logic [DQ_W-1:0]   pd_q [3];
  logic [NB-1:0]     dm1_q;
  logic [NB-1:0]     msk_q;
  logic [15:0]       rcnt_q;
  logic              perr_q;

  logic [3:0]        cmd;
  logic [NBK-1:0]    bsel;
  logic [NBK-1:0]    pmask;
  logic [NBK-1:0]    open_eff;
  logic              rw_cmd;
  logic              rw_ok;
  logic              new_b;
  logic              iss;
  logic              iss_wr;
  logic              stop;
  logic              last;
  logic              lmr_ok;
  logic              err;
  logic [BANK_W-1:0] i_bank;
  logic [ROW_W-1:0]  i_row;
  logic [COL_W-1:0]  i_col;
  logic [1:0]        i_blc;
  logic [2:0]        i_k;
  logic [2:0]        i_last;
  logic              i_ap;
  logic [COL_W-1:0]  wmask;
  logic [COL_W-1:0]  wcol;
  logic [MW-1:0]     idx;
  logic [1:0]        ci;

  // Decode the command and select the word the burst engine issues now.
  always_comb begin
    cmd = cs ? C_NOP : {1'b0, ras, cas, we};
    bsel = '0;
    bsel[ba] = 1'b1;
    pmask = '0;
    pmask[pbank_q] = pcl_q;
    open_eff = open_q & ~pmask;
    rw_cmd = (cmd == C_RD) || (cmd == C_WR);
    rw_ok = open_eff[ba];
    new_b = rw_cmd && rw_ok;
    iss = 1'b0;
    iss_wr = 1'b0;
    i_bank = bbank_q;
    i_row = brow_q;
    i_col = bcol_q;
    i_blc = bblc_q;
    i_k = bk_q;
    i_last = blast_q;
    i_ap = bap_q;
    if (new_b) begin
      iss = 1'b1;
      iss_wr = (cmd == C_WR);
      i_bank = ba;
      i_row = row_q[ba];
      i_col = a[COL_W-1:0];
      i_blc = bl_q;
      i_k = '0;
      i_last = (iss_wr && swr_q) ? 3'd0
             : 3'((4'd1 << bl_q) - 4'd1);
      i_ap = a[10];
    end else if (bst_q != B_IDLE) begin
      iss = 1'b1;
      iss_wr = (bst_q == B_WRITE);
    end
    wmask = COL_W'((11'd1 << i_blc) - 11'd1);
    wcol = (i_col & ~wmask)
         | ((i_col + COL_W'(i_k)) & wmask);
    idx = {i_row, i_bank, wcol};
    last = (i_k == i_last);
    // The word scheduled for this edge still goes out; issue stops after.
    stop = !new_b && ((cmd == C_BST) ||
           ((cmd == C_PRE) && (a[10] || (ba == bbank_q))));
    lmr_ok = !(|open_eff) && !a[2] && (a[6:5] == 2'b01);
    open_d = open_eff;
    if (cmd == C_ACT) open_d = open_d | bsel;
    if (cmd == C_PRE) open_d = a[10] ? '0 : (open_d & ~bsel);
    err = ((cmd == C_ACT) && open_eff[ba])
        || (rw_cmd && !rw_ok)
        || ((cmd == C_LMR) && !lmr_ok)
        || ((cmd == C_REF) && (|open_eff));
    ci = cl3_q ? 2'd2 : 2'd1;
  end

  // Mode, bank, burst engine, read pipeline and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bl_q <= 2'd0;
      cl3_q <= 1'b0;
      swr_q <= 1'b0;
      open_q <= '0;
      for (int i = 0; i < NBK; i++) row_q[i] <= '0;
      bst_q <= B_IDLE;
      bbank_q <= '0;
      brow_q <= '0;
      bcol_q <= '0;
      bblc_q <= '0;
      bk_q <= '0;
      blast_q <= '0;
      bap_q <= 1'b0;
      pcl_q <= 1'b0;
      pbank_q <= '0;
      pv_q <= '0;
      for (int i = 0; i < 3; i++) pd_q[i] <= '0;
      dm1_q <= '0;
      msk_q <= '0;
      rcnt_q <= '0;
      perr_q <= 1'b0;
    end else if (cke) begin
      open_q <= open_d;
      if (cmd == C_ACT) row_q[ba] <= a[ROW_W-1:0];
      if ((cmd == C_LMR) && lmr_ok) begin
        bl_q <= a[1:0];
        cl3_q <= a[4];
        swr_q <= a[9];
      end
      if ((cmd == C_REF) && !(|open_eff)) rcnt_q <= rcnt_q + 16'd1;
      if (err) perr_q <= 1'b1;
      pcl_q <= iss && last && i_ap;
      pbank_q <= i_bank;
      if (iss) begin
        bbank_q <= i_bank;
        brow_q <= i_row;
        bcol_q <= i_col;
        bblc_q <= i_blc;
        blast_q <= i_last;
        bap_q <= i_ap;
        bk_q <= i_k + 3'd1;
        bst_q <= (last || stop) ? B_IDLE
               : (iss_wr ? B_WRITE : B_READ);
      end
      dm1_q <= dqm;
      msk_q <= dm1_q;
      pv_q <= {1'b0, pv_q[2:1]};
      pd_q[0] <= pd_q[1];
      pd_q[1] <= pd_q[2];
      if (iss && !iss_wr) begin
        pv_q[ci] <= 1'b1;
        pd_q[ci] <= mem[idx];
      end
      if (new_b && iss_wr) pv_q <= '0;
    end
  end

  // Write-burst data capture with per-lane DQM masking.
  always_ff @(posedge clk) begin
    if (!reset && cke && iss && iss_wr) begin
      for (int i = 0; i < NB; i++)
        if (!dqm[i]) mem[idx][8*i +: 8] <= dq[8*i +: 8];
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign dq[8*g +: 8] = (pv_q[0] && !msk_q[g])
                        ? pd_q[0][8*g +: 8] : 8'hzz;
  end

  assign refresh_cnt = rcnt_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_sdram_dev_model.sv
// tb_sdram_dev_model: directed bench for the SDRAM device model:
// bursts, wrap order, DQM, BST, auto-precharge, refresh and freeze.
module tb_sdram_dev_model;
  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic        cs;
  logic        ras;
  logic        cas;
  logic        we;
  logic [12:0] a;
  logic [1:0]  ba;
  logic [1:0]  dqm;
  wire  [15:0] dq;
  logic [15:0] tb_d;
  logic        tb_oe;
  logic [15:0] refresh_cnt;
  logic        proto_err;
  int          checks = 0;
  int          failures = 0;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  assign dq = tb_oe ? tb_d : 16'hzzzz;

  always #5 clk = ~clk;

  sdram_dev_model #(
    .DQ_W(16), .ROW_W(9), .COL_W(9), .BANK_W(2), .A_W(13)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .cs(cs), .ras(ras), .cas(cas), .we(we),
    .a(a), .ba(ba), .dqm(dqm), .dq(dq),
    .refresh_cnt(refresh_cnt), .proto_err(proto_err)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] c, input logic [12:0] ad,
                       input logic [1:0] b);
    {cs, ras, cas, we} = c;
    a = ad;
    ba = b;
    step();
    {cs, ras, cas, we} = NOP;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bench pulls the bus to 0; any model drive shows as non-zero or X.
  task automatic chkz(input string tag);
    tb_oe = 1'b1;
    tb_d = 16'h0000;
    #1;
    chk(tag, {16'h0, dq}, 32'h0);
    tb_oe = 1'b0;
  endtask

  task automatic wr4(input logic [12:0] ad, input logic [63:0] d,
                     input logic [7:0] m);
    tb_oe = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tb_d = d[16*k +: 16];
      dqm = m[2*k +: 2];
      if (k == 0) begin
        {cs, ras, cas, we} = WR;
        a = ad;
        ba = 2'd1;
      end else begin
        {cs, ras, cas, we} = NOP;
      end
      step();
    end
    tb_oe = 1'b0;
    dqm = 2'b00;
    {cs, ras, cas, we} = NOP;
  endtask

  task automatic rd_chk(input string tag, input logic [12:0] ad,
                        input int cl, input logic [63:0] exp);
    issue(RD, ad, 2'd1);
    repeat (cl - 1) step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_w%0d", tag, k), {16'h0, dq},
          {16'h0, exp[16*k +: 16]});
      step();
    end
    chkz({tag, "_z"});
  endtask

  initial begin
    reset = 1'b1;
    cke = 1'b1;
    {cs, ras, cas, we} = 4'b1111;
    a = '0;
    ba = '0;
    dqm = '0;
    tb_oe = 1'b0;
    tb_d = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_perr", {31'h0, proto_err}, 32'h0);
    chk("rst_rcnt", {16'h0, refresh_cnt}, 32'h0);
    chkz("rst_dq");

    issue(LMR, 13'h022, 2'd0);
    issue(ACT, 13'h0AB, 2'd1);
    wr4(13'h004, 64'h4444_3333_2222_1111, 8'h00);
    rd_chk("cl2", 13'h004, 2, 64'h4444_3333_2222_1111);

    issue(PRE, 13'h400, 2'd0);
    issue(LMR, 13'h032, 2'd0);
    issue(ACT, 13'h0AB, 2'd1);
    rd_chk("cl3wrap", 13'h006, 3, 64'h2222_1111_4444_3333);

    wr4(13'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    wr4(13'h010, 64'h4444_3333_2222_1111, 8'h04);
    rd_chk("dqm", 13'h010, 3, 64'h4444_3333_22FF_1111);

    issue(PRE, 13'h400, 2'd0);
    issue(LMR, 13'h023, 2'd0);
    issue(ACT, 13'h0AB, 2'd1);
    issue(RD, 13'h010, 2'd1);
    step();
    chk("bst_w0", {16'h0, dq}, 32'h1111);
    issue(BST, 13'h000, 2'd0);
    chk("bst_w1", {16'h0, dq}, 32'h22FF);
    step();
    chk("bst_w2", {16'h0, dq}, 32'h3333);
    step();
    chkz("bst_z0");
    step();
    chkz("bst_z1");

    chk("ap_perr0", {31'h0, proto_err}, 32'h0);
    issue(RD, 13'h410, 2'd1);
    repeat (12) step();
    issue(RD, 13'h010, 2'd1);
    chk("ap_perr1", {31'h0, proto_err}, 32'h1);
    chkz("ap_z0");
    step();
    chkz("ap_z1");
    step();
    chkz("ap_z2");

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_perr", {31'h0, proto_err}, 32'h0);
    issue(ACT, 13'h005, 2'd0);
    issue(REF, 13'h000, 2'd0);
    chk("ref_err", {31'h0, proto_err}, 32'h1);
    chk("ref_cnt0", {16'h0, refresh_cnt}, 32'h0);
    issue(PRE, 13'h400, 2'd0);
    issue(REF, 13'h000, 2'd0);
    issue(REF, 13'h000, 2'd0);
    chk("ref_cnt2", {16'h0, refresh_cnt}, 32'h2);

    reset = 1'b1;
    step();
    reset = 1'b0;
    issue(LMR, 13'h022, 2'd0);
    issue(ACT, 13'h0AB, 2'd1);
    issue(RD, 13'h004, 2'd1);
    step();
    chk("frz_w0", {16'h0, dq}, 32'h1111);
    cke = 1'b0;
    repeat (5) step();
    chk("frz_hold", {16'h0, dq}, 32'h1111);
    cke = 1'b1;
    step();
    chk("frz_w1", {16'h0, dq}, 32'h2222);
    step();
    chk("frz_w2", {16'h0, dq}, 32'h3333);
    step();
    chk("frz_w3", {16'h0, dq}, 32'h4444);
    step();
    chkz("frz_z");
    chk("frz_perr", {31'h0, proto_err}, 32'h0);

    issue(PRE, 13'h400, 2'd0);
    issue(LMR, 13'h047, 2'd0);
    chk("lmr_bad", {31'h0, proto_err}, 32'h1);
    issue(ACT, 13'h0AB, 2'd1);
    rd_chk("lmr_keep", 13'h004, 2, 64'h4444_3333_2222_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
